defuse_sequencer: RTL and testbench
===================================

// Module: defuse_sequencer
// PURPOSE
//  Game controller for the cable/key check. Stores the secret key and counts down a timer.
//  Samples {cable1,cable2} on each pulse of the player's "pulsed" button and steps through
//  the key positions. Counts tries and reports defused/exploded.
//  Sits between the board I/O (button, two cables) and the status LEDs/display.
// PARAMETERS
//  KEY_LEN      4     number of code entries per attempt (>=2)
//  CODE_W       2     bits per entry ({cable1,cable2})
//  MAX_TRIES    3     wrong full sequences allowed before explosion (1..15)
//  TIMEOUT_CYC  1000  clk cycles allowed from arm to explosion (>=KEY_LEN*8)
// PORTS
//  clk          in   1               system clock, rising edge
//  rst_n        in   1               asynchronous active-low reset
//  start        in   1               arm request, level, sampled each clk
//  pulsed       in   1               entry button, asynchronous to clk
//  cable1       in   1               code bit 1 (MSB), asynchronous
//  cable2       in   1               code bit 0 (LSB), asynchronous
//  key_we       in   1               key write strobe, honoured only in IDLE
//  key_idx      in   $clog2(KEY_LEN) key position to write
//  key_data     in   CODE_W          key value to write
//  step         out  $clog2(KEY_LEN) next key position expected
//  tries_left   out  4               remaining tries
//  time_left    out  $clog2(TIMEOUT_CYC+1)  remaining cycles
//  strike       out  1               1-cycle pulse: wrong full sequence, tries remain
//  result       out  2               00 IDLE, 01 ARMED, 10 DEFUSED, 11 EXPLODED
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, key[] = 0, step = 0, tries_left = MAX_TRIES,
//   time_left = TIMEOUT_CYC, strike = 0, result = 00, mismatch flag = 0.
//  pulsed, cable1 and cable2 all pass through 2-flop synchronisers with identical delay.
//   A rising edge of synced pulsed gives ent = 1 for one cycle.
//   The code is taken as {cable1_s,cable2_s} in the same cycle.
//   Cables must be stable for 3 clk around the pulse edge.
//  Latency: pulsed rises -> ent on 3rd clk edge -> step/result/strike update on 4th edge.
//  IDLE: key_we writes key[key_idx] = key_data.
//   start = 1 -> ARMED, with step = 0, tries_left = MAX_TRIES, time_left = TIMEOUT_CYC, mismatch = 0.
//  ARMED: time_left decrements by 1 every cycle; key_we is ignored; start is ignored.
//   On ent: mismatch |= (code != key[step]).
//   If step < KEY_LEN-1: step++.
//   If step == KEY_LEN-1 (final entry) and no mismatch including this entry: go to DEFUSED.
//   If step == KEY_LEN-1 with a mismatch: tries_left--.
//    If the result is 0: go to EXPLODED.
//    Otherwise: step = 0, mismatch = 0, strike = 1 for one cycle.
//   time_left == 1 and no deciding ent in this cycle: EXPLODED next edge, with time_left = 0.
//   Simultaneous events: a correct final entry in the same cycle as timer expiry -> DEFUSED (player wins).
//    A wrong final entry in the same cycle as expiry -> EXPLODED, no strike.
//  DEFUSED / EXPLODED: all counters frozen and the outputs hold.
//   start = 1 -> re-arm, same as from IDLE. The key is kept.
//  ent while IDLE, DEFUSED or EXPLODED: ignored, no side effects.
//  step wraps only through the rules above; it never exceeds KEY_LEN-1.
//  Reset mid-game: immediate IDLE and the key is cleared.
//  result encoding is fixed; the display decoder depends on it.
// STRUCTURE
//  defuse_pkg: state enum {IDLE,ARMED,DEFUSED,EXPLODED}, RES_* 2-bit constants, CODE_W default.
//  Sub-module sync_edge (instanced 3x, edge output used for pulsed only):
//   2-flop synchroniser plus rising-edge detect, async active-low reset to 0.
//  Top level holds the key register file, the FSM, and the step/tries/timer counters.
// TESTING
//  T1 Load key {0,1,2,3}, start, then pulses with codes 0,1,2,3 spaced 8 clk ->
//     step 0->1->2->3, result 10 on the 4th edge after the last pulse; no strike.
//  T2 Key {0,1,2,3}, codes 3,2,1,0 -> strike = 1 for 1 clk, tries_left 3->2, step = 0,
//     result stays 01; then the correct sequence -> result 10.
//  T3 MAX_TRIES=3, three wrong sequences -> two strikes, then result 11, tries_left = 0.
//  T4 TIMEOUT_CYC=100, start, no pulses -> result 11 at exactly 100 clk after arm.
//     Also a correct final pulse timed to land ent on the expiry cycle -> result 10.
//  T5 key_we during ARMED with key_idx=0, key_data=3 -> key unchanged (code 0 still accepted).
//     A pulse shorter than 1 clk -> no entry.
//  T6 rst_n low mid-entry at step 2 -> all outputs at their reset values asynchronously,
//     key = 0; start, then codes 0,0,0,0 -> result 10.

Source files
------------

// File: rtl/defuse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : defuse_pkg
//  Description : Shared types and constants for the cable/key defuse game:
//                game-state enum, result codes and the default entry width.
//  Revision    : 1.0  initial release
// ============================================================================
package defuse_pkg;

  // Two cables give a 2-bit code per entry by default.
  localparam int CODE_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ARMED    = 2'b01,
    DEFUSED  = 2'b10,
    EXPLODED = 2'b11
  } state_t;

  // The display decoder relies on these codes, so they are pinned here
  // instead of being inferred from the enum encoding.
  localparam logic [1:0] RES_IDLE     = 2'b00;
  localparam logic [1:0] RES_ARMED    = 2'b01;
  localparam logic [1:0] RES_DEFUSED  = 2'b10;
  localparam logic [1:0] RES_EXPLODED = 2'b11;

  function automatic logic [1:0] state_to_result(input state_t s);
    logic [1:0] r;
    case (s)
      IDLE:     r = RES_IDLE;
      ARMED:    r = RES_ARMED;
      DEFUSED:  r = RES_DEFUSED;
      default:  r = RES_EXPLODED;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/defuse_sequencer_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Two-flop synchroniser followed by a registered rising-edge
//                detector. The level output is delayed to line up exactly
//                with the edge pulse, so several instances stay aligned.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_dly;
  logic r_rise;

  // Synchronise the input, keep one delayed copy, and register the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_dly  <= r_sync;
      r_rise <= r_sync & ~r_dly;
    end
  end

  // r_dly carries the same sample that produced r_rise, so level and edge
  // refer to the same input instant.
  assign o_level = r_dly;
  assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/defuse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : defuse_sequencer
//  Description : Cable/key game controller. Holds the secret key, counts the
//                countdown timer, samples the cable code on each button press
//                and reports armed / defused / exploded.
//  Revision    : 1.0  initial release
// ============================================================================
module defuse_sequencer
  import defuse_pkg::*;
#(
  parameter  int KEY_LEN     = 4,
  parameter  int CODE_W      = CODE_W_DEF,
  parameter  int MAX_TRIES   = 3,
  parameter  int TIMEOUT_CYC = 1000,
  localparam int STEP_W      = $clog2(KEY_LEN),
  localparam int TIME_W      = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pulsed,
  input  logic              cable1,
  input  logic              cable2,
  input  logic              key_we,
  input  logic [STEP_W-1:0] key_idx,
  input  logic [CODE_W-1:0] key_data,
  output logic [STEP_W-1:0] step,
  output logic [3:0]        tries_left,
  output logic [TIME_W-1:0] time_left,
  output logic              strike,
  output logic [1:0]        result
);

  localparam logic [STEP_W-1:0] c_last_step = STEP_W'(KEY_LEN - 1);
  localparam logic [3:0]        c_max_tries = 4'(MAX_TRIES);
  localparam logic [TIME_W-1:0] c_timeout   = TIME_W'(TIMEOUT_CYC);
  localparam logic [TIME_W-1:0] c_time_one  = TIME_W'(1);

  state_t            r_state, w_state_nxt;
  logic [CODE_W-1:0] r_key [KEY_LEN];
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic [3:0]        r_tries, w_tries_nxt;
  logic [TIME_W-1:0] r_time, w_time_nxt;
  logic              r_mm, w_mm_nxt;
  logic              r_strike, w_strike_nxt;

  logic              w_ent;
  logic              w_c1;
  logic              w_c2;
  logic [1:0]        w_unused_cable_rise;
  logic [CODE_W-1:0] w_code;
  logic              w_mm_now;
  logic              w_expire;

  // Button and both cables share one synchroniser design so the code is
  // valid in exactly the cycle the entry pulse appears.
  sync_edge u_sync_pulsed (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (pulsed),
    .o_level (),
    .o_rise  (w_ent)
  );

  sync_edge u_sync_cable1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (cable1),
    .o_level (w_c1),
    .o_rise  (w_unused_cable_rise[1])
  );

  sync_edge u_sync_cable2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (cable2),
    .o_level (w_c2),
    .o_rise  (w_unused_cable_rise[0])
  );

  assign w_code   = CODE_W'({w_c1, w_c2});
  assign w_mm_now = r_mm | (w_code != r_key[r_step]);
  assign w_expire = (r_time == c_time_one);

  // Key register file: writable only while idle, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_LEN; i++) begin
        r_key[i] <= '0;
      end
    end else if (r_state == IDLE && key_we) begin
      r_key[key_idx] <= key_data;
    end
  end

  // Game state and counters register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_step   <= '0;
      r_tries  <= c_max_tries;
      r_time   <= c_timeout;
      r_mm     <= 1'b0;
      r_strike <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_tries  <= w_tries_nxt;
      r_time   <= w_time_nxt;
      r_mm     <= w_mm_nxt;
      r_strike <= w_strike_nxt;
    end
  end

  // Next-state logic: entry evaluation, strikes, timer expiry and re-arm.
  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_tries_nxt  = r_tries;
    w_time_nxt   = r_time;
    w_mm_nxt     = r_mm;
    w_strike_nxt = 1'b0;
    case (r_state)
      ARMED: begin
        w_time_nxt = r_time - 1'b1;
        if (w_ent) begin
          if (r_step != c_last_step) begin
            w_step_nxt = r_step + 1'b1;
            w_mm_nxt   = w_mm_now;
            if (w_expire) begin
              w_state_nxt = EXPLODED;
            end
          end else if (!w_mm_now) begin
            // A correct final entry wins even on the expiry cycle.
            w_state_nxt = DEFUSED;
          end else begin
            w_tries_nxt = r_tries - 1'b1;
            if (r_tries == 4'd1 || w_expire) begin
              w_state_nxt = EXPLODED;
            end else begin
              w_step_nxt   = '0;
              w_mm_nxt     = 1'b0;
              w_strike_nxt = 1'b1;
            end
          end
        end else if (w_expire) begin
          w_state_nxt = EXPLODED;
        end
      end
      default: begin
        // IDLE, DEFUSED and EXPLODED all hold until start; entries ignored.
        if (start) begin
          w_state_nxt = ARMED;
          w_step_nxt  = '0;
          w_tries_nxt = c_max_tries;
          w_time_nxt  = c_timeout;
          w_mm_nxt    = 1'b0;
        end
      end
    endcase
  end

  assign step       = r_step;
  assign tries_left = r_tries;
  assign time_left  = r_time;
  assign strike     = r_strike;
  assign result     = state_to_result(r_state);

endmodule
`default_nettype wire

// File: tb/tb_defuse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_defuse_sequencer
//  Description : Self-checking bench for defuse_sequencer with an
//                entry-level reference model of the game rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_defuse_sequencer;

  localparam int KL = 4;
  localparam int MT = 3;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n, start, pulsed, cable1, cable2, key_we;
  logic [1:0] key_idx, key_data;
  wire  [1:0] step;
  wire  [3:0] tries_left;
  wire  [6:0] time_left;
  wire        strike;
  wire  [1:0] result;

  defuse_sequencer #(
    .KEY_LEN(KL), .CODE_W(2), .MAX_TRIES(MT), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pulsed(pulsed),
    .cable1(cable1), .cable2(cable2), .key_we(key_we), .key_idx(key_idx),
    .key_data(key_data), .step(step), .tries_left(tries_left),
    .time_left(time_left), .strike(strike), .result(result)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model (entry level) ----------------
  typedef struct { int land; int code; } ent_t;
  int   edge_cnt = 0;
  int   m_state, m_deadline, m_tries, m_time_hold;
  bit   m_strike;
  int   m_key [KL];
  int   m_attempt [$];
  ent_t pend [$];

  task automatic model_reset();
    m_state = 0; m_tries = MT; m_time_hold = TO; m_strike = 0; m_deadline = 0;
    for (int i = 0; i < KL; i++) m_key[i] = 0;
    m_attempt.delete();
    pend.delete();
  endtask

  task automatic freeze(input int s);
    m_state = s;
    m_time_hold = m_deadline - edge_cnt;
  endtask

  task automatic model_edge();
    bit has_ent; int code; bit ok; ent_t e;
    m_strike = 0; has_ent = 0; code = 0;
    if (pend.size() > 0 && pend[0].land == edge_cnt) begin
      e = pend.pop_front(); has_ent = 1; code = e.code;
    end
    if (m_state == 1) begin
      if (has_ent) begin
        m_attempt.push_back(code);
        if (m_attempt.size() == KL) begin
          ok = 1;
          foreach (m_attempt[i]) if (m_attempt[i] != m_key[i]) ok = 0;
          if (ok) freeze(2);
          else begin
            m_tries--;
            if (m_tries == 0 || edge_cnt == m_deadline) freeze(3);
            else begin m_attempt.delete(); m_strike = 1; end
          end
        end else if (edge_cnt == m_deadline) freeze(3);
      end else if (edge_cnt == m_deadline) freeze(3);
    end else begin
      if (m_state == 0 && key_we) m_key[key_idx] = int'(key_data);
      if (start) begin
        m_state = 1; m_deadline = edge_cnt + TO; m_tries = MT; m_attempt.delete();
      end
    end
  endtask

  function automatic logic [15:0] exp_vec();
    int s; int t;
    s = (m_attempt.size() > KL - 1) ? KL - 1 : m_attempt.size();
    t = (m_state == 1) ? (m_deadline - edge_cnt) : m_time_hold;
    return {2'(m_state), 2'(s), 4'(m_tries), 7'(t), m_strike};
  endfunction

  wire [15:0] act_vec = {result, step, tries_left, time_left, strike};

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin edge_cnt++; model_edge(); end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic entry(input int code);
    cable1 = code[1]; cable2 = code[0];
    @(negedge clk);
    pulsed = 1'b1;
    pend.push_back('{edge_cnt + 4, code});
    repeat (2) @(negedge clk);
    pulsed = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic arm();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic load_key(input int k0, input int k1, input int k2, input int k3);
    int k [KL];
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    for (int i = 0; i < KL; i++) begin
      key_we = 1'b1; key_idx = 2'(i); key_data = 2'(k[i]);
      @(negedge clk);
    end
    key_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; @(negedge clk);
    total++;
    if (act_vec !== {2'b00, 2'd0, 4'd3, 7'd100, 1'b0}) begin
      bad++; $display("FAIL reset_values act=%h exp=%h", act_vec, {2'b00, 2'd0, 4'd3, 7'd100, 1'b0});
    end
    rst_n = 1'b1; @(negedge clk);
    total++;
    if (act_vec !== exp_vec()) begin
      bad++; $display("FAIL reset_release act=%h exp=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_defuse();
    load_key(0, 1, 2, 3);
    arm();
    total++;
    if ({result, time_left} !== {2'b01, 7'd100}) begin
      bad++; $display("FAIL t1_armed act=%b/%0d exp=01/100", result, time_left);
    end
    for (int i = 0; i < KL - 1; i++) begin
      entry(i); repeat (3) @(negedge clk);
      total++;
      if (step !== 2'(i + 1) || act_vec !== exp_vec()) begin
        bad++; $display("FAIL t1_step%0d act=%h exp=%h", i, act_vec, exp_vec());
      end
    end
    cable1 = 1'b1; cable2 = 1'b1; @(negedge clk);
    pulsed = 1'b1; pend.push_back('{edge_cnt + 4, 3});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) pulsed = 1'b0;
      total++;
      if (result !== ((k < 4) ? 2'b01 : 2'b10) || strike !== 1'b0) begin
        bad++; $display("FAIL t1_latency_edge%0d act=%b/%b exp=%b/0", k, result, strike, (k < 4) ? 2'b01 : 2'b10);
      end
    end
  endtask

  task automatic test_wrong_then_right();
    arm();
    for (int i = 3; i >= 0; i--) entry(i);
    total++;
    if ({result, step, tries_left, strike} !== {2'b01, 2'd0, 4'd2, 1'b1}) begin
      bad++; $display("FAIL t2_strike act=%b exp=%b", {result, step, tries_left, strike}, {2'b01, 2'd0, 4'd2, 1'b1});
    end
    @(negedge clk);
    total++;
    if (strike !== 1'b0 || act_vec !== exp_vec()) begin
      bad++; $display("FAIL t2_strike_1cyc act=%h exp=%h", act_vec, exp_vec());
    end
    for (int i = 0; i < KL; i++) entry(i);
    total++;
    if (result !== 2'b10 || act_vec !== exp_vec()) begin
      bad++; $display("FAIL t2_defuse act=%h exp=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_three_wrong();
    int strikes = 0;
    arm();
    for (int s = 0; s < MT; s++) begin
      for (int i = 0; i < KL; i++) entry(3);
      strikes += int'(strike);
      total++;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL t3_seq%0d act=%h exp=%h", s, act_vec, exp_vec());
      end
    end
    total++;
    if (strikes != 2 || result !== 2'b11 || tries_left !== 4'd0) begin
      bad++; $display("FAIL t3_explode strikes=%0d res=%b tries=%0d exp 2/11/0", strikes, result, tries_left);
    end
  endtask

  task automatic test_timeout();
    int a;
    int tgt;
    arm(); a = edge_cnt;
    for (int k = 0; k < 200 && edge_cnt < a + TO - 1; k++) @(negedge clk);
    total++;
    if (edge_cnt != a + TO - 1 || result !== 2'b01 || time_left !== 7'd1) begin
      bad++; $display("FAIL t4_before_expiry edge=%0d res=%b time=%0d exp 01/1", edge_cnt - a, result, time_left);
    end
    @(negedge clk);
    total++;
    if (result !== 2'b11 || time_left !== 7'd0 || act_vec !== exp_vec()) begin
      bad++; $display("FAIL t4_expiry act=%h exp=%h", act_vec, exp_vec());
    end
    // final entry landing on the expiry cycle: correct wins, wrong explodes
    for (int pass = 0; pass < 2; pass++) begin
      arm(); a = edge_cnt;
      for (int i = 0; i < KL - 1; i++) entry(i);
      tgt = a + TO - 5;
      for (int k = 0; k < 200 && edge_cnt < tgt; k++) @(negedge clk);
      entry(pass == 0 ? 3 : 0);
      total++;
      if (result !== (pass == 0 ? 2'b10 : 2'b11) || strike !== 1'b0 || act_vec !== exp_vec()) begin
        bad++; $display("FAIL t4_race%0d act=%h exp=%h", pass, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_key_we_armed();
    arm();
    key_we = 1'b1; key_idx = 2'd0; key_data = 2'd3; @(negedge clk); key_we = 1'b0;
    #1 pulsed = 1'b1; #2 pulsed = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (step !== 2'd0 || act_vec !== exp_vec()) begin
      bad++; $display("FAIL t5_short_pulse act=%h exp=%h", act_vec, exp_vec());
    end
    for (int i = 0; i < KL; i++) entry(i);
    total++;
    if (result !== 2'b10 || act_vec !== exp_vec()) begin
      bad++; $display("FAIL t5_key_locked act=%h exp=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    arm();
    entry(0); entry(1);
    total++;
    if (step !== 2'd2) begin
      bad++; $display("FAIL t6_step2 act=%0d exp=2", step);
    end
    cable1 = 1'b1; cable2 = 1'b0; @(negedge clk);
    pulsed = 1'b1; #2 rst_n = 1'b0; #1;
    total++;
    if (act_vec !== {2'b00, 2'd0, 4'd3, 7'd100, 1'b0}) begin
      bad++; $display("FAIL t6_async_reset act=%h exp=%h", act_vec, {2'b00, 2'd0, 4'd3, 7'd100, 1'b0});
    end
    pulsed = 1'b0;
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    arm();
    for (int i = 0; i < KL; i++) entry(0);
    total++;
    if (result !== 2'b10 || act_vec !== exp_vec()) begin
      bad++; $display("FAIL t6_key_cleared act=%h exp=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int code; int n; int s;
    for (int r = 0; r < 10; r++) begin
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
      load_key($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      arm();
      n = 0;
      while (m_state == 1 && n < 24) begin
        s = (m_attempt.size() > KL - 1) ? KL - 1 : m_attempt.size();
        code = ($urandom_range(0, 3) != 0) ? m_key[s] : int'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: begin key_we = 1'b1; key_idx = 2'($urandom_range(0, 3)); key_data = 2'($urandom_range(0, 3));
                   @(negedge clk); key_we = 1'b0; end
          1: begin start = 1'b1; @(negedge clk); start = 1'b0; end
          default: ;
        endcase
        repeat ($urandom_range(0, 4)) @(negedge clk);
        entry(code);
        n++;
        total++;
        if (act_vec !== exp_vec()) begin
          bad++; $display("FAIL rnd%0d_entry%0d act=%h exp=%h", r, n, act_vec, exp_vec());
        end
      end
      repeat (TO + 5) @(negedge clk);
      total++;
      if (act_vec !== exp_vec() || result === 2'b01) begin
        bad++; $display("FAIL rnd%0d_final act=%h exp=%h", r, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pulsed = 1'b0; cable1 = 1'b0; cable2 = 1'b0;
    key_we = 1'b0; key_idx = 2'd0; key_data = 2'd0;
    @(negedge clk);
    test_reset();
    test_defuse();
    test_wrong_then_right();
    test_three_wrong();
    test_timeout();
    test_key_we_armed();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
